// File: rtl/encode_mul_pipe_rs_if.sv
// Sample bus for encode_mul_pipe_rs: clock enable, operand inputs and the
// rounded/saturated result with its valid and clip flags.
interface encode_mul_pipe_rs_if #(
    parameter int din0_WIDTH = 14,
    parameter int din1_WIDTH = 12,
    parameter int dout_WIDTH = 16
);
    logic                  ce;
    logic                  in_valid;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [dout_WIDTH-1:0] dout;
    logic                  out_valid;
    logic                  sat;

    modport master (
        output ce, in_valid, din0, din1,
        input  dout, out_valid, sat
    );

    modport slave (
        input  ce, in_valid, din0, din1,
        output dout, out_valid, sat
    );
endinterface

// File: rtl/encode_mul_pipe_rs.sv
// Pipelined signed multiplier with round-half-up right shift and signed
// saturation. Stage 1 registers the exact product (or the final result when
// only one stage is built); rounding and clipping happen in front of the
// final-stage registers, which drive the outputs directly.
module encode_mul_pipe_rs #(
    parameter int din0_WIDTH  = 14,
    parameter int din1_WIDTH  = 12,
    parameter int dout_WIDTH  = 16,
    parameter int NUM_STAGE   = 3,
    parameter int SHIFT       = 8,
    parameter int DIN1_SIGNED = 0
) (
    input logic                 clk,
    input logic                 reset,
    encode_mul_pipe_rs_if.slave bus
);

    // Exact product width, plus one guard bit for the rounding add.
    localparam int PW = din0_WIDTH + din1_WIDTH + 1;
    localparam int RW = PW + 1;
    localparam logic signed [RW-1:0] RND =
        (SHIFT == 0) ? '0 : (RW'(1) << ((SHIFT == 0) ? 0 : SHIFT - 1));

    logic signed [din0_WIDTH-1:0] a_in;
    logic        [din1_WIDTH-1:0] b_in;
    logic signed [PW-1:0]         a_ext;
    logic signed [PW-1:0]         b_ext;
    logic signed [PW-1:0]         prod;
    logic signed [PW-1:0]         src;

    logic [dout_WIDTH-1:0] dout_d, dout_q;
    logic                  sat_d, sat_q;
    logic [NUM_STAGE-1:0]  vld_d, vld_q;

    assign a_in = bus.din0;
    assign b_in = bus.din1;

    // Returns {sat, dout}: round, shift, then clip to the output range.
    function automatic logic [dout_WIDTH:0] round_sat(input logic signed [PW-1:0] p);
        logic signed [RW-1:0]      t;
        logic signed [RW-1:0]      r;
        logic [RW-dout_WIDTH:0]    hi;
        logic [dout_WIDTH:0]       res;
        t  = {p[PW-1], p};
        t  = t + RND;
        r  = t >>> SHIFT;
        hi = r[RW-1:dout_WIDTH-1];
        if ((&hi) || !(|hi)) begin
            res = {1'b0, r[dout_WIDTH-1:0]};
        end else if (r[RW-1]) begin
            res = {1'b1, 1'b1, {(dout_WIDTH-1){1'b0}}};
        end else begin
            res = {1'b1, 1'b0, {(dout_WIDTH-1){1'b1}}};
        end
        return res;
    endfunction

    // Extend both operands to the product width and form the exact product.
    always_comb begin
        a_ext = {{(PW-din0_WIDTH){a_in[din0_WIDTH-1]}}, a_in};
        b_ext = {{(PW-din1_WIDTH){(DIN1_SIGNED != 0) & b_in[din1_WIDTH-1]}}, b_in};
        prod  = a_ext * b_ext;
    end

    generate
        if (NUM_STAGE == 1) begin : g_one
            assign src = prod;
        end else begin : g_multi
            logic signed [PW-1:0] p_d [NUM_STAGE-1];
            logic signed [PW-1:0] p_q [NUM_STAGE-1];

            // Product delay line; every stage loads on ce regardless of in_valid.
            always_comb begin
                p_d = p_q;
                if (bus.ce) begin
                    p_d[0] = prod;
                    for (int i = 1; i < NUM_STAGE - 1; i++) begin
                        p_d[i] = p_q[i-1];
                    end
                end
            end

            // Product stage registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int i = 0; i < NUM_STAGE - 1; i++) begin
                        p_q[i] <= '0;
                    end
                end else begin
                    p_q <= p_d;
                end
            end

            assign src = p_q[NUM_STAGE-2];
        end
    endgenerate

    // Final-stage result and valid shift register, both held while ce is low.
    always_comb begin
        dout_d = dout_q;
        sat_d  = sat_q;
        vld_d  = vld_q;
        if (bus.ce) begin
            {sat_d, dout_d} = round_sat(src);
            vld_d[0] = bus.in_valid;
            for (int i = 1; i < NUM_STAGE; i++) begin
                vld_d[i] = vld_q[i-1];
            end
        end
    end

    // Output and valid registers; reset wins over ce.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_q <= '0;
            sat_q  <= 1'b0;
            vld_q  <= '0;
        end else begin
            dout_q <= dout_d;
            sat_q  <= sat_d;
            vld_q  <= vld_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.sat       = sat_q;
    assign bus.out_valid = vld_q[NUM_STAGE-1];

endmodule

// File: tb/tb_encode_mul_pipe_rs.sv
// Directed bench for encode_mul_pipe_rs: default build, a signed/no-shift
// wide-output build, and 1- and 8-stage builds under random ce/in_valid.
module tb_encode_mul_pipe_rs;

   logic clk;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   typedef struct {
      logic [15:0] d;
      bit          s;
      int          idx;
   } exp_t;

   encode_mul_pipe_rs_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16)) if0 ();
   encode_mul_pipe_rs_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26)) if1 ();
   encode_mul_pipe_rs_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16)) if2 ();
   encode_mul_pipe_rs_if #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16)) if3 ();

   encode_mul_pipe_rs #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16),
                        .NUM_STAGE(3), .SHIFT(8), .DIN1_SIGNED(0))
      u0 (.clk(clk), .reset(reset), .bus(if0.slave));
   encode_mul_pipe_rs #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(26),
                        .NUM_STAGE(3), .SHIFT(0), .DIN1_SIGNED(1))
      u1 (.clk(clk), .reset(reset), .bus(if1.slave));
   encode_mul_pipe_rs #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16),
                        .NUM_STAGE(1), .SHIFT(8), .DIN1_SIGNED(0))
      u2 (.clk(clk), .reset(reset), .bus(if2.slave));
   encode_mul_pipe_rs #(.din0_WIDTH(14), .din1_WIDTH(12), .dout_WIDTH(16),
                        .NUM_STAGE(8), .SHIFT(8), .DIN1_SIGNED(0))
      u3 (.clk(clk), .reset(reset), .bus(if3.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: exact product, round half up, arithmetic shift, clip.
   function automatic void model(input logic [13:0] a, input logic [11:0] b,
                                 output logic [15:0] d, output bit s);
      longint p, r, mx, mn;
      p  = longint'($signed(a)) * longint'({20'b0, b});
      r  = (p + 128) >>> 8;
      mx = 32767;
      mn = -32768;
      s  = 1'b0;
      if (r > mx) begin r = mx; s = 1'b1; end
      else if (r < mn) begin r = mn; s = 1'b1; end
      d = 16'(r);
   endfunction

   initial begin
      logic [15:0] md;
      bit          ms;
      logic [15:0] exp_d[$];
      bit          exp_s[$];
      exp_t        q2[$];
      exp_t        q3[$];
      exp_t        ent;
      bit          pat[5];
      bit          prev_ov;
      logic [15:0] prev_d;
      int          sent, rcvd, e;
      bit          rce, riv;
      logic [13:0] ra;
      logic [11:0] rb;

      reset = 1'b0;
      if0.ce = 1'b1; if0.in_valid = 1'b0; if0.din0 = '0; if0.din1 = '0;
      if1.ce = 1'b1; if1.in_valid = 1'b0; if1.din0 = '0; if1.din1 = '0;
      if2.ce = 1'b0; if2.in_valid = 1'b0; if2.din0 = '0; if2.din1 = '0;
      if3.ce = 1'b0; if3.in_valid = 1'b0; if3.din0 = '0; if3.din1 = '0;

      #1 reset = 1'b1;
      #2;
      chk("rst_dout", if0.dout, 16'h0000);
      chk("rst_ov", if0.out_valid, 1'b0);
      chk("rst_sat", if0.sat, 1'b0);
      tick();
      tick();
      reset = 1'b0;

      if0.din0 = 14'd100; if0.din1 = 12'd200; if0.in_valid = 1'b1;
      tick();
      if0.in_valid = 1'b0; if0.din0 = 14'h1234; if0.din1 = 12'h777;
      tick();
      chk("lat_early_ov", if0.out_valid, 1'b0);
      tick();
      chk("s100_ov", if0.out_valid, 1'b1);
      chk("s100_dout", if0.dout, 16'd78);
      chk("s100_sat", if0.sat, 1'b0);
      tick();
      chk("s100_pulse_end", if0.out_valid, 1'b0);

      if0.in_valid = 1'b1;
      if0.din0 = 14'h3FFD; if0.din1 = 12'd128;  tick();
      if0.din0 = 14'd8191; if0.din1 = 12'd4095; tick();
      if0.din0 = 14'h2000; if0.din1 = 12'd4095; tick();
      if0.in_valid = 1'b0;
      chk("neg3_ov", if0.out_valid, 1'b1);
      chk("neg3_dout", if0.dout, 16'hFFFF);
      chk("neg3_sat", if0.sat, 1'b0);
      tick();
      chk("satp_ov", if0.out_valid, 1'b1);
      chk("satp_dout", if0.dout, 16'h7FFF);
      chk("satp_sat", if0.sat, 1'b1);
      tick();
      chk("satn_ov", if0.out_valid, 1'b1);
      chk("satn_dout", if0.dout, 16'h8000);
      chk("satn_sat", if0.sat, 1'b1);
      tick();
      chk("b2b_end_ov", if0.out_valid, 1'b0);
      tick(); tick();

      pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
      sent = 0; rcvd = 0;
      for (int k = 0; k < 200 && rcvd < 10; k++) begin
         if0.ce = pat[k % 5];
         if (pat[k % 5] && sent < 10) begin
            if0.in_valid = 1'b1;
            if0.din0 = 14'(sent * 1234 - 6000);
            if0.din1 = 12'(sent * 397 + 11);
            model(if0.din0, if0.din1, md, ms);
            exp_d.push_back(md);
            exp_s.push_back(ms);
            sent++;
         end else if (!pat[k % 5]) begin
            if0.in_valid = 1'b1;
            if0.din0 = 14'h1555;
            if0.din1 = 12'hABC;
         end else begin
            if0.in_valid = 1'b0;
         end
         prev_ov = if0.out_valid;
         prev_d  = if0.dout;
         tick();
         if (pat[k % 5]) begin
            if (if0.out_valid) begin
               chk("stream_expected_pending", exp_d.size() > 0, 1'b1);
               if (exp_d.size() > 0) begin
                  chk("stream_dout", if0.dout, exp_d[0]);
                  chk("stream_sat", if0.sat, exp_s[0]);
                  void'(exp_d.pop_front());
                  void'(exp_s.pop_front());
                  rcvd++;
               end
            end
         end else begin
            chk("stream_hold_ov", if0.out_valid, prev_ov);
            chk("stream_hold_dout", if0.dout, prev_d);
         end
      end
      chk("stream_count", rcvd, 10);
      chk("stream_left", exp_d.size(), 0);
      if0.ce = 1'b1; if0.in_valid = 1'b0;
      tick(); tick(); tick(); tick();

      if0.in_valid = 1'b1; if0.din0 = 14'd8191; if0.din1 = 12'd4095;
      tick(); tick(); tick();
      chk("pre_rst_ov", if0.out_valid, 1'b1);
      chk("pre_rst_sat", if0.sat, 1'b1);
      #2 reset = 1'b1;
      #1;
      chk("async_rst_dout", if0.dout, 16'h0000);
      chk("async_rst_sat", if0.sat, 1'b0);
      chk("async_rst_ov", if0.out_valid, 1'b0);
      if0.in_valid = 1'b0;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("post_rst_no_ov", if0.out_valid, 1'b0);
      end
      if0.in_valid = 1'b1; if0.din0 = 14'd100; if0.din1 = 12'd200;
      tick();
      if0.in_valid = 1'b0;
      tick();
      chk("post_rst_early", if0.out_valid, 1'b0);
      tick();
      chk("post_rst_ov", if0.out_valid, 1'b1);
      chk("post_rst_dout", if0.dout, 16'd78);

      if1.in_valid = 1'b1;
      if1.din0 = 14'h3FFB; if1.din1 = 12'hFF9; tick();
      if1.din0 = 14'h2000; if1.din1 = 12'h800; tick();
      if1.in_valid = 1'b0;
      tick();
      chk("sgn_a_ov", if1.out_valid, 1'b1);
      chk("sgn_a_dout", if1.dout, 26'd35);
      chk("sgn_a_sat", if1.sat, 1'b0);
      tick();
      chk("sgn_b_ov", if1.out_valid, 1'b1);
      chk("sgn_b_dout", if1.dout, 26'd16777216);
      chk("sgn_b_sat", if1.sat, 1'b0);

      e = 0;
      for (int k = 0; k < 420; k++) begin
         if (k < 400) begin
            rce = ($urandom_range(0, 3) != 0);
            riv = ($urandom_range(0, 2) != 0);
         end else begin
            rce = 1'b1;
            riv = 1'b0;
         end
         ra = 14'($urandom);
         rb = 12'($urandom);
         if2.ce = rce; if2.in_valid = riv; if2.din0 = ra; if2.din1 = rb;
         if3.ce = rce; if3.in_valid = riv; if3.din0 = ra; if3.din1 = rb;
         if (rce) begin
            if (riv) begin
               model(ra, rb, md, ms);
               ent.d = md; ent.s = ms; ent.idx = e;
               q2.push_back(ent);
               q3.push_back(ent);
            end
            e++;
         end
         tick();
         if (rce) begin
            if (if2.out_valid) begin
               chk("ns1_pending", q2.size() > 0, 1'b1);
               if (q2.size() > 0) begin
                  chk("ns1_dout", if2.dout, q2[0].d);
                  chk("ns1_sat", if2.sat, q2[0].s);
                  chk("ns1_latency", e - q2[0].idx, 1);
                  void'(q2.pop_front());
               end
            end
            if (if3.out_valid) begin
               chk("ns8_pending", q3.size() > 0, 1'b1);
               if (q3.size() > 0) begin
                  chk("ns8_dout", if3.dout, q3[0].d);
                  chk("ns8_sat", if3.sat, q3[0].s);
                  chk("ns8_latency", e - q3[0].idx, 8);
                  void'(q3.pop_front());
               end
            end
         end
      end
      chk("ns1_left", q2.size(), 0);
      chk("ns8_left", q3.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/encode_mul_pipe_rs.md
ENCODE_MUL_PIPE_RS -- requirements
Module: encode_mul_pipe_rs

Interface
REQ-001 SHALL have parameter din0_WIDTH, default 14, width of signed operand din0.
REQ-002 SHALL have parameter din1_WIDTH, default 12, width of operand din1.
REQ-003 SHALL have parameter dout_WIDTH, default 16, width of signed result dout.
REQ-004 SHALL have parameter NUM_STAGE, default 3, pipeline depth in register stages (legal range 1..8).
REQ-005 SHALL have parameter SHIFT, default 8, right-shift applied to the full product (legal range 0..din0_WIDTH+din1_WIDTH-1).
REQ-006 SHALL have parameter DIN1_SIGNED, default 0; 0 = din1 unsigned (zero-extended), 1 = din1 two's complement.
REQ-007 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-009 SHALL have port ce, input, 1, clock enable for every pipeline stage.
REQ-010 SHALL have port in_valid, input, 1, marks din0/din1 as a valid sample.
REQ-011 SHALL have port din0, input, din0_WIDTH, signed multiplicand.
REQ-012 SHALL have port din1, input, din1_WIDTH, multiplier, signedness per DIN1_SIGNED.
REQ-013 SHALL have port dout, output, dout_WIDTH, rounded, shifted, saturated signed product.
REQ-014 SHALL have port out_valid, output, 1, marks dout as the result of a valid input sample.
REQ-015 SHALL have port sat, output, 1, high when the dout sample was clipped; aligned with dout.

Function
REQ-016 Full product P SHALL be exact, width din0_WIDTH+din1_WIDTH+1, signed; din1 extended per DIN1_SIGNED.
REQ-017 For SHIFT>0, R SHALL be (P + 2^(SHIFT-1)) arithmetically shifted right by SHIFT (round half toward +inf); for SHIFT=0, R = P.
REQ-018 R SHALL be computed without overflow (one guard bit above P).
REQ-019 If R > 2^(dout_WIDTH-1)-1, dout SHALL be 2^(dout_WIDTH-1)-1 and sat SHALL be 1.
REQ-020 If R < -2^(dout_WIDTH-1), dout SHALL be -2^(dout_WIDTH-1) and sat SHALL be 1.
REQ-021 Otherwise dout SHALL equal R truncated to dout_WIDTH and sat SHALL be 0.
REQ-022 Data path SHALL be NUM_STAGE register stages: stage 1 registers operands or product, rounding/saturation no later than final stage; dout/sat/out_valid driven directly from final-stage registers.
REQ-023 A valid sample SHALL have latency exactly NUM_STAGE ce-high cycles from input to out_valid.
REQ-024 in_valid SHALL travel through a NUM_STAGE-deep valid shift register in lockstep with data.
REQ-025 When ce=0, all data, sat and valid registers SHALL hold; no sample lost or duplicated across any ce pattern.
REQ-026 Data registers SHALL load on every ce-high edge regardless of in_valid; only out_valid qualifies dout.
REQ-027 Back-to-back valid samples (in_valid high every ce cycle) SHALL produce out_valid high every ce cycle, throughput 1/cycle.
REQ-028 in_valid asserted while ce=0 SHALL be ignored (not captured).

Reset
REQ-029 reset high SHALL immediately, without clock, clear all data stages, valid bits and sat to 0; dout=0, out_valid=0, sat=0.
REQ-030 reset asserted mid-stream SHALL discard all in-flight samples; no out_valid pulse SHALL result from pre-reset inputs.
REQ-031 First valid sample after reset deassertion SHALL appear exactly NUM_STAGE ce cycles later.
REQ-032 reset SHALL take priority over ce.

Verification (defaults: 14/12/16, SHIFT=8, NUM_STAGE=3, DIN1_SIGNED=0)
REQ-033 din0=100, din1=200, in_valid=1, ce=1 -> after 3 cycles dout=78, sat=0, out_valid=1 for one cycle.
REQ-034 din0=-3, din1=128 -> dout=-1, sat=0; din0=8191, din1=4095 -> dout=32767, sat=1; din0=-8192, din1=4095 -> dout=-32768, sat=1.
REQ-035 Stream of 10 valid samples with ce toggled 1,0,1,1,0,... -> 10 out_valid pulses, in order, each matching the reference model, none during ce=0 cycles.
REQ-036 Two valid samples in flight, reset pulsed asynchronously between edges -> outputs 0 at once, no out_valid for either sample; next sample out after 3 cycles.
REQ-037 DIN1_SIGNED=1, SHIFT=0, dout_WIDTH=26: din0=-5, din1=-7 (0xFF9) -> dout=35, sat=0; din0=-8192, din1=-2048 -> dout=16777216, sat=0.
REQ-038 NUM_STAGE=1 and NUM_STAGE=8 builds with random operands -> latency 1 and 8 respectively, bit-exact versus model, random ce and in_valid.
